// File: rtl/pow5_root_pkg.sv
// Shared types and constants for the iterative fifth-root unit.
package pow5_root_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        MUL,
        CMP,
        DONE
    } state_t;

    localparam int MUL_STEPS      = 4;
    localparam int CYCLES_PER_BIT = 6;

endpackage

// File: rtl/pow5_root_step.sv
// Combinational step of the fifth-root bit search: trial-bit generation,
// truncating prod*trial multiply and the unsigned fit test against the radicand.
module pow5_root_step
    import pow5_root_pkg::*;
#(
    parameter int W  = 8,
    parameter int BW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]   root_q,
    input  logic [BW-1:0]  bit_idx,
    input  logic [W-1:0]   trial,
    input  logic [5*W-1:0] prod,
    input  logic [5*W-1:0] rad_q,
    output logic [W-1:0]   trial_next,
    output logic [5*W-1:0] prod_next,
    output logic           fits
);

    always_comb begin
        trial_next = root_q | (W'(1) << bit_idx);
        // trial < 2^W, so trial^5 always fits in 5W bits and truncation loses nothing
        prod_next  = prod * {{(4*W){1'b0}}, trial};
        fits       = (prod <= rad_q);
    end

endmodule

// File: rtl/pow5_root.sv
// Iterative floor fifth root of a 5W-bit radicand, MSB-first bit search.
// Define POW5_ROOT_REMAINDER_EN to add the remainder output (rad_q - root^5).
module pow5_root
    import pow5_root_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5*W-1:0] radicand,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   root
`ifdef POW5_ROOT_REMAINDER_EN
    ,
    output logic [5*W-1:0] remainder
`endif
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int MW = $clog2(MUL_STEPS);

    state_t         state_q, state_d;
    logic [5*W-1:0] rad_q;
    logic [W-1:0]   root_q;
    logic [W-1:0]   trial_q;
    logic [5*W-1:0] prod_q;
    logic [BW-1:0]  bit_q;
    logic [MW-1:0]  mul_cnt_q;
`ifdef POW5_ROOT_REMAINDER_EN
    logic [5*W-1:0] acc_pow_q;
`endif

    logic [W-1:0]   trial_next;
    logic [5*W-1:0] prod_next;
    logic           fits;

    pow5_root_step #(
        .W  (W),
        .BW (BW)
    ) u_step (
        .root_q     (root_q),
        .bit_idx    (bit_q),
        .trial      (trial_q),
        .prod       (prod_q),
        .rad_q      (rad_q),
        .trial_next (trial_next),
        .prod_next  (prod_next),
        .fits       (fits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready) state_d = SET;
            SET:     state_d = MUL;
            MUL:     if (mul_cnt_q == MW'(MUL_STEPS - 1)) state_d = CMP;
            CMP:     state_d = (bit_q == '0) ? DONE : SET;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q     <= '0;
            root_q    <= '0;
            trial_q   <= '0;
            prod_q    <= '0;
            bit_q     <= '0;
            mul_cnt_q <= '0;
`ifdef POW5_ROOT_REMAINDER_EN
            acc_pow_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rad_q  <= radicand;
                        root_q <= '0;
                        bit_q  <= BW'(W - 1);
`ifdef POW5_ROOT_REMAINDER_EN
                        acc_pow_q <= '0;
`endif
                    end
                end
                SET: begin
                    trial_q   <= trial_next;
                    prod_q    <= {{(4*W){1'b0}}, trial_next};
                    mul_cnt_q <= '0;
                end
                MUL: begin
                    prod_q    <= prod_next;
                    mul_cnt_q <= mul_cnt_q + MW'(1);
                end
                CMP: begin
                    // prod_q now holds trial^5; keep the bit only if it does not overshoot
                    if (fits) begin
                        root_q <= trial_q;
`ifdef POW5_ROOT_REMAINDER_EN
                        acc_pow_q <= prod_q;
`endif
                    end
                    if (bit_q != '0) bit_q <= bit_q - BW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        root      = out_valid ? root_q : '0;
`ifdef POW5_ROOT_REMAINDER_EN
        remainder = out_valid ? (rad_q - acc_pow_q) : '0;
`endif
    end

endmodule
